// File: rtl/pll_lock_qualifier.sv
// Synchronises and debounces the raw PLL lock into a registered pll_ok level, with loss-fault reporting.
// Optional macro PLL_GLITCH_CNT_EN adds a saturating count of absorbed dropouts on glitch_count.
//
// state    | meaning
// UNLOCKED | no lock seen, pll_ok low
// QUALIFY  | counting consecutive high samples, pll_ok low
// LOCKED   | lock qualified, pll_ok high
// DROP     | counting consecutive low samples, pll_ok still high

module pll_lock_qualifier #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 1000,
  parameter int DROP_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_locked_raw,
  input  logic       clear_fault,
  output logic       pll_ok,
  output logic       lock_lost,
  output logic [7:0] loss_count,
  output logic [7:0] glitch_count
);

  // Shared counter must also reach DROP_CYCLES-1 if drop filtering is ever longer than qualification.
  localparam int CNT_RANGE = (LOCK_CYCLES > DROP_CYCLES) ? LOCK_CYCLES : DROP_CYCLES;
  localparam int CNT_W     = (CNT_RANGE > 1) ? $clog2(CNT_RANGE) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DROP_LAST = CNT_W'(DROP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_QUALIFY  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;
  localparam logic [1:0] ST_DROP     = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   loss_evt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_raw};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign loss_evt = (state_q == ST_DROP) && !locked_s && (cnt_q == DROP_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (locked_s) begin
          state_d = ST_QUALIFY;
          cnt_d   = '0;
        end
      end
      ST_QUALIFY: begin
        if (!locked_s)              state_d = ST_UNLOCKED;
        else if (cnt_q == LOCK_LAST) state_d = ST_LOCKED;
        else                        cnt_d   = cnt_q + CNT_ONE;
      end
      ST_LOCKED: begin
        if (!locked_s) begin
          state_d = ST_DROP;
          cnt_d   = CNT_ONE;
        end
      end
      ST_DROP: begin
        if (locked_s)                state_d = ST_LOCKED;
        else if (cnt_q == DROP_LAST) state_d = ST_UNLOCKED;
        else                         cnt_d   = cnt_q + CNT_ONE;
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  // pll_ok is its own flop so the reset timer never sees decode glitches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_UNLOCKED;
      cnt_q   <= '0;
      pll_ok  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pll_ok  <= (state_d == ST_LOCKED) || (state_d == ST_DROP);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lock_lost  <= 1'b0;
      loss_count <= 8'd0;
    end else begin
      if (loss_evt)         lock_lost <= 1'b1;
      else if (clear_fault) lock_lost <= 1'b0;

      if (clear_fault)                          loss_count <= loss_evt ? 8'd1 : 8'd0;
      else if (loss_evt && loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
    end
  end

`ifdef PLL_GLITCH_CNT_EN
  logic glitch_evt;

  assign glitch_evt = (state_q == ST_DROP) && locked_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                               glitch_count <= 8'd0;
    else if (clear_fault)                       glitch_count <= glitch_evt ? 8'd1 : 8'd0;
    else if (glitch_evt && glitch_count != 8'hFF) glitch_count <= glitch_count + 8'd1;
  end
`else
  assign glitch_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_qualifier.sv
// Directed self-checking bench for pll_lock_qualifier (SYNC=2, LOCK=16, DROP=4).
module tb_pll_lock_qualifier;

  logic       clock;
  logic       reset_n;
  logic       pll_locked_raw;
  logic       clear_fault;
  logic       pll_ok;
  logic       lock_lost;
  logic [7:0] loss_count;
  logic [7:0] glitch_count;

  int tests;
  int fails;

`ifdef PLL_GLITCH_CNT_EN
  localparam logic [7:0] GLITCH_ONE = 8'd1;
`else
  localparam logic [7:0] GLITCH_ONE = 8'd0;
`endif

  pll_lock_qualifier #(
    .SYNC_STAGES(2),
    .LOCK_CYCLES(16),
    .DROP_CYCLES(4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pll_locked_raw(pll_locked_raw),
    .clear_fault   (clear_fault),
    .pll_ok        (pll_ok),
    .lock_lost     (lock_lost),
    .loss_count    (loss_count),
    .glitch_count  (glitch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input logic raw);
    reset_n        = 1'b0;
    pll_locked_raw = raw;
    clear_fault    = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic go_locked();
    pll_locked_raw = 1'b1;
    repeat (25) step();
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    pll_locked_raw = 1'b1;
    clear_fault    = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    tests++; if (pll_ok !== 1'b0)       begin fails++; $display("FAIL reset_pll_ok got %b want 0", pll_ok); end
    tests++; if (lock_lost !== 1'b0)    begin fails++; $display("FAIL reset_lock_lost got %b want 0", lock_lost); end
    tests++; if (loss_count !== 8'd0)   begin fails++; $display("FAIL reset_loss_count got %0d want 0", loss_count); end
    tests++; if (glitch_count !== 8'd0) begin fails++; $display("FAIL reset_glitch_count got %0d want 0", glitch_count); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      step();
      tests++;
      if (pll_ok !== (i == 19)) begin
        fails++; $display("FAIL first_lock edge %0d pll_ok got %b want %b", i, pll_ok, (i == 19));
      end
    end
  endtask

  task automatic test_interrupted_qualify();
    apply_reset(1'b0);
    pll_locked_raw = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      tests++; if (pll_ok !== 1'b0) begin fails++; $display("FAIL intq_pre edge %0d pll_ok got %b want 0", i, pll_ok); end
    end
    pll_locked_raw = 1'b0;
    step();
    tests++; if (pll_ok !== 1'b0) begin fails++; $display("FAIL intq_drop pll_ok got %b want 0", pll_ok); end
    pll_locked_raw = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      step();
      tests++;
      if (pll_ok !== (i == 19)) begin
        fails++; $display("FAIL intq_relock edge %0d pll_ok got %b want %b", i, pll_ok, (i == 19));
      end
    end
  endtask

  task automatic test_absorbed_glitch();
    apply_reset(1'b0);
    go_locked();
    pll_locked_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 4) pll_locked_raw = 1'b1;
      step();
      tests++; if (pll_ok !== 1'b1) begin fails++; $display("FAIL glitch edge %0d pll_ok got %b want 1", i, pll_ok); end
    end
    tests++; if (lock_lost !== 1'b0)        begin fails++; $display("FAIL glitch_lock_lost got %b want 0", lock_lost); end
    tests++; if (loss_count !== 8'd0)       begin fails++; $display("FAIL glitch_loss_count got %0d want 0", loss_count); end
    tests++; if (glitch_count !== GLITCH_ONE) begin fails++; $display("FAIL glitch_count got %0d want %0d", glitch_count, GLITCH_ONE); end
  endtask

  task automatic test_loss_relock();
    pll_locked_raw = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      tests++;
      if (pll_ok !== (i < 6)) begin fails++; $display("FAIL loss edge %0d pll_ok got %b want %b", i, pll_ok, (i < 6)); end
    end
    tests++; if (lock_lost !== 1'b1)  begin fails++; $display("FAIL loss_lock_lost got %b want 1", lock_lost); end
    tests++; if (loss_count !== 8'd1) begin fails++; $display("FAIL loss_count got %0d want 1", loss_count); end
    pll_locked_raw = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      step();
      tests++;
      if (pll_ok !== (i == 19)) begin fails++; $display("FAIL relock edge %0d pll_ok got %b want %b", i, pll_ok, (i == 19)); end
    end
    tests++; if (lock_lost !== 1'b1) begin fails++; $display("FAIL relock_lock_lost got %b want 1", lock_lost); end
  endtask

  task automatic test_clear_and_saturation();
    // glitch coincident with clear: counter restarts at 1, loss fault cleared
    pll_locked_raw = 1'b0;
    step(); step(); step();
    pll_locked_raw = 1'b1;
    step(); step();
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    tests++; if (glitch_count !== GLITCH_ONE) begin fails++; $display("FAIL clr_glitch_count got %0d want %0d", glitch_count, GLITCH_ONE); end
    tests++; if (lock_lost !== 1'b0)  begin fails++; $display("FAIL clr_lock_lost got %b want 0", lock_lost); end
    tests++; if (loss_count !== 8'd0) begin fails++; $display("FAIL clr_loss_count got %0d want 0", loss_count); end
    tests++; if (pll_ok !== 1'b1)     begin fails++; $display("FAIL clr_pll_ok got %b want 1", pll_ok); end
    step(); step();
    // previous loss leaves loss_count at 1 before the coincident clear
    pll_locked_raw = 1'b0;
    repeat (6) step();
    pll_locked_raw = 1'b1;
    repeat (22) step();
    tests++; if (loss_count !== 8'd1) begin fails++; $display("FAIL pre_prio_loss_count got %0d want 1", loss_count); end
    pll_locked_raw = 1'b0;
    repeat (5) step();
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    tests++; if (lock_lost !== 1'b1)  begin fails++; $display("FAIL prio_lock_lost got %b want 1", lock_lost); end
    tests++; if (loss_count !== 8'd1) begin fails++; $display("FAIL prio_loss_count got %0d want 1", loss_count); end
    tests++; if (pll_ok !== 1'b0)     begin fails++; $display("FAIL prio_pll_ok got %b want 0", pll_ok); end
    for (int n = 0; n < 300; n++) begin
      pll_locked_raw = 1'b1;
      repeat (20) step();
      pll_locked_raw = 1'b0;
      repeat (6) step();
      if (n == 252) begin
        tests++; if (loss_count !== 8'd254) begin fails++; $display("FAIL sat_pre loss_count got %0d want 254", loss_count); end
      end
    end
    tests++; if (loss_count !== 8'd255) begin fails++; $display("FAIL sat loss_count got %0d want 255", loss_count); end
    tests++; if (lock_lost !== 1'b1)    begin fails++; $display("FAIL sat_lock_lost got %b want 1", lock_lost); end
  endtask

  task automatic test_reset_mid_qualify();
    pll_locked_raw = 1'b1;
    repeat (11) step();
    reset_n = 1'b0;
    #1;
    tests++; if (pll_ok !== 1'b0)       begin fails++; $display("FAIL midrst_pll_ok got %b want 0", pll_ok); end
    tests++; if (lock_lost !== 1'b0)    begin fails++; $display("FAIL midrst_lock_lost got %b want 0", lock_lost); end
    tests++; if (loss_count !== 8'd0)   begin fails++; $display("FAIL midrst_loss_count got %0d want 0", loss_count); end
    tests++; if (glitch_count !== 8'd0) begin fails++; $display("FAIL midrst_glitch_count got %0d want 0", glitch_count); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      step();
      tests++;
      if (pll_ok !== (i == 19)) begin fails++; $display("FAIL midrst_relock edge %0d pll_ok got %b want %b", i, pll_ok, (i == 19)); end
    end
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    reset_n        = 1'b0;
    pll_locked_raw = 1'b0;
    clear_fault    = 1'b0;
    test_reset();
    test_interrupted_qualify();
    test_absorbed_glitch();
    test_loss_relock();
    test_clear_and_saturation();
    test_reset_mid_qualify();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
